// File: rtl/rx_vc_router.sv
// Receive-side VC router: decodes the TLP traffic class, tags each TLP with VC0/VC1,
// and drains a 2-entry in-order holding buffer into the matching RX VC FIFO.
module rx_vc_router #(
    parameter int         TLP_W       = 224,
    parameter logic [7:0] TC_VC1_MASK = 8'hFE,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TLP_W-1:0] tlp_i,
    input  logic             tlp_valid_i,
    output logic             tlp_ready_o,
    input  logic             vc0_full,
    input  logic             vc1_full,
    output logic [TLP_W-1:0] vc_data_o,
    output logic             wr_en_vc0,
    output logic             wr_en_vc1,
    output logic [CNT_W-1:0] vc0_cnt_o,
    output logic [CNT_W-1:0] vc1_cnt_o
);

    logic [TLP_W-1:0] data_q [2];
    logic [1:0]       tag_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [TLP_W-1:0] last_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic [2:0] tc;
    logic       head_valid;
    logic       head_tag;
    logic       push;
    logic       pop;

    // Traffic class lives in DW0 bits 22:20.
    assign tc          = tlp_i[TLP_W-10:TLP_W-12];
    assign head_valid  = (occ != 2'd0);
    assign head_tag    = tag_q[rd_ptr];
    assign tlp_ready_o = (occ != 2'd2) && !rst;
    assign push        = tlp_valid_i && tlp_ready_o;

    // Strictly in-order: a blocked head stalls everything behind it.
    assign wr_en_vc0 = head_valid && !head_tag && !vc0_full;
    assign wr_en_vc1 = head_valid &&  head_tag && !vc1_full;
    assign pop       = wr_en_vc0 || wr_en_vc1;

    assign vc_data_o = head_valid ? data_q[rd_ptr] : last_q;
    assign vc0_cnt_o = cnt0_q;
    assign vc1_cnt_o = cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            tag_q     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            last_q    <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= tlp_i;
                tag_q[wr_ptr]  <= TC_VC1_MASK[tc];
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Remember the head so the data bus holds steady once the buffer drains.
            if (head_valid) begin
                last_q <= data_q[rd_ptr];
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (wr_en_vc0) cnt0_q <= cnt0_q + 1'b1;
            if (wr_en_vc1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

endmodule
